// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and state type for the multiply/divide sequencer and the
// control-signal decoder.
package multdiv_sequencer_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam int unsigned ITER_DEFAULT  = 32;
  localparam int unsigned RSTATUS_REG   = 30;
  localparam int unsigned MUL_OVF_CODE  = 4;
  localparam int unsigned DIV_ZERO_CODE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for multi-cycle units: load clears, enable counts up,
// tc flags the last iteration (ITER-1).
module multdiv_iter_counter #(
  parameter int unsigned ITER = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(ITER) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(ITER - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle controller for the iterative multiply/divide datapath: stalls the
// pipeline for ITER step cycles, then issues one write-back (rd or rstatus).
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned ITER          = ITER_DEFAULT,
  parameter int unsigned RSTATUS_REG   = multdiv_sequencer_pkg::RSTATUS_REG,
  parameter int unsigned MUL_OVF_CODE  = multdiv_sequencer_pkg::MUL_OVF_CODE,
  parameter int unsigned DIV_ZERO_CODE = multdiv_sequencer_pkg::DIV_ZERO_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  rd,
  input  logic        flush,
  input  logic        dp_zero_divisor,
  input  logic        dp_overflow,
  output logic        stall,
  output logic        dp_load,
  output logic        dp_step,
  output logic        dp_is_div,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_sel_status,
  output logic [31:0] wb_status
);

  state_e     state_q, state_d;
  logic [4:0] rd_q;
  logic       is_div_q;
  logic       div0_q;
  logic       accept;
  logic       cnt_tc;
  logic       exc;

  assign accept = (state_q == IDLE) && in_valid && is_multdiv(opcode, aluop) && !flush;

  multdiv_iter_counter #(
    .ITER (ITER)
  ) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .en    (state_q == RUN),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q     <= rd;
        is_div_q <= aluop[0];
        div0_q   <= aluop[0] & dp_zero_divisor;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    dp_load       = 1'b0;
    dp_step       = 1'b0;
    dp_is_div     = 1'b0;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    wb_sel_status = 1'b0;
    wb_status     = '0;
    exc           = 1'b0;

    case (state_q)
      IDLE: begin
        stall     = accept;
        dp_load   = accept;
        dp_is_div = accept & aluop[0];
        if (accept) begin
          state_d = (aluop[0] & dp_zero_divisor) ? DONE : RUN;
        end
      end
      RUN: begin
        stall     = 1'b1;
        dp_step   = 1'b1;
        dp_is_div = is_div_q;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dp_is_div = is_div_q;
        state_d   = IDLE;
        exc       = div0_q | (!is_div_q & dp_overflow);
        if (exc) begin
          wb_valid      = !flush;
          wb_rd         = 5'(RSTATUS_REG);
          wb_sel_status = 1'b1;
          wb_status     = div0_q ? 32'(DIV_ZERO_CODE) : 32'(MUL_OVF_CODE);
        end else begin
          // $r0 is hardwired: a non-exception result targeting it is dropped
          wb_valid = (rd_q != 5'd0) && !flush;
          wb_rd    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!reset) begin
      stall         = 1'b0;
      dp_load       = 1'b0;
      dp_step       = 1'b0;
      dp_is_div     = 1'b0;
      wb_valid      = 1'b0;
      wb_rd         = '0;
      wb_sel_status = 1'b0;
      wb_status     = '0;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed, table-driven bench for multdiv_sequencer with hand-written
// sequences for flush, reset and back-to-back issue.
module tb_multdiv_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic [4:0]  rd;
  logic        flush;
  logic        dp_zero_divisor;
  logic        dp_overflow;
  logic        stall;
  logic        dp_load;
  logic        dp_step;
  logic        dp_is_div;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_sel_status;
  logic [31:0] wb_status;

  int unsigned checks = 0;
  int unsigned errors = 0;

  multdiv_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .opcode          (opcode),
    .aluop           (aluop),
    .rd              (rd),
    .flush           (flush),
    .dp_zero_divisor (dp_zero_divisor),
    .dp_overflow     (dp_overflow),
    .stall           (stall),
    .dp_load         (dp_load),
    .dp_step         (dp_step),
    .dp_is_div       (dp_is_div),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_sel_status   (wb_sel_status),
    .wb_status       (wb_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        is_div;
    logic [4:0]  rd;
    logic        zdiv;
    logic        ovf;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic        exp_sel;
    logic [31:0] exp_status;
    int unsigned lat;
  } vec_t;

  function automatic vec_t mk(input string name, input logic is_div, input logic [4:0] r,
                              input logic zdiv, input logic ovf, input logic ev,
                              input logic [4:0] er, input logic es, input logic [31:0] est,
                              input int unsigned lat);
    vec_t v;
    v.name = name; v.is_div = is_div; v.rd = r; v.zdiv = zdiv; v.ovf = ovf;
    v.exp_valid = ev; v.exp_rd = er; v.exp_sel = es; v.exp_status = est; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; opcode = 5'd0; aluop = 5'd0; rd = 5'd0;
    flush = 1'b0; dp_zero_divisor = 1'b0;
  endtask

  task automatic start_op(input logic is_div, input logic [4:0] r, input logic zdiv);
    in_valid = 1'b1; opcode = 5'b00000; aluop = is_div ? 5'b00111 : 5'b00110;
    rd = r; dp_zero_divisor = zdiv; flush = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {stall, dp_load, dp_step, dp_is_div, wb_valid, wb_rd, wb_sel_status} | wb_status;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 of the cycle after DONE+1.
  task automatic run_vector(input vec_t v);
    int unsigned steps;
    int unsigned bad;
    start_op(v.is_div, v.rd, v.zdiv);
    dp_overflow = v.ovf;
    @(negedge clock);
    check({v.name, " accept stall"}, 32'(stall), 32'(1));
    check({v.name, " accept dp_load"}, 32'(dp_load), 32'(1));
    check({v.name, " accept dp_is_div"}, 32'(dp_is_div), 32'(v.is_div));
    next_cycle;
    idle_inputs;
    steps = 0;
    bad = 0;
    for (int unsigned c = 1; c < v.lat; c++) begin
      @(negedge clock);
      if (dp_step && stall && !wb_valid && !dp_load) steps++;
      if (dp_is_div !== v.is_div) bad++;
      next_cycle;
    end
    check({v.name, " step cycles"}, steps, v.lat - 1);
    check({v.name, " is_div held"}, bad, 32'(0));
    @(negedge clock);
    check({v.name, " done stall/step"}, 32'({stall, dp_step}), 32'(0));
    check({v.name, " done wb_valid"}, 32'(wb_valid), 32'(v.exp_valid));
    check({v.name, " done wb_rd"}, 32'(wb_rd), 32'(v.exp_rd));
    check({v.name, " done wb_sel_status"}, 32'(wb_sel_status), 32'(v.exp_sel));
    check({v.name, " done wb_status"}, wb_status, v.exp_status);
    check({v.name, " done dp_is_div"}, 32'(dp_is_div), 32'(v.is_div));
    next_cycle;
    @(negedge clock);
    check({v.name, " back to idle"}, 32'({stall, dp_step, wb_valid}), 32'(0));
    next_cycle;
    dp_overflow = 1'b0;
  endtask

  vec_t vecs[6];

  typedef struct {
    logic       v;
    logic [4:0] opc;
    logic [4:0] fn;
  } nonmd_t;

  nonmd_t nonmd[4];

  initial begin
    int unsigned pulses;

    vecs[0] = mk("mul_rd5",     1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 32'd0, 33);
    vecs[1] = mk("div0_rd7",    1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 5'd30, 1'b1, 32'd5, 1);
    vecs[2] = mk("mulovf_rd0",  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 5'd30, 1'b1, 32'd4, 33);
    vecs[3] = mk("mul_rd0",     1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'd0, 33);
    vecs[4] = mk("div_ovfign",  1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 32'd0, 33);
    vecs[5] = mk("mul_zdivign", 1'b0, 5'd31, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 32'd0, 33);

    nonmd[0] = '{1'b1, 5'b00000, 5'b00000};
    nonmd[1] = '{1'b1, 5'b00000, 5'b00001};
    nonmd[2] = '{1'b1, 5'b01000, 5'b00110};
    nonmd[3] = '{1'b0, 5'b00000, 5'b00111};

    // Reset held low with a valid mul presented
    reset = 1'b0;
    dp_overflow = 1'b0;
    start_op(1'b0, 5'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("reset outputs zero", all_outs(), 32'(0));
      next_cycle;
    end
    reset = 1'b1;

    foreach (vecs[i]) run_vector(vecs[i]);

    // Non-mul/div instructions never stall
    pulses = 0;
    foreach (nonmd[i]) begin
      in_valid = nonmd[i].v; opcode = nonmd[i].opc; aluop = nonmd[i].fn; rd = 5'd3;
      @(negedge clock);
      if (stall || dp_load || dp_step) pulses++;
      next_cycle;
    end
    idle_inputs;
    @(negedge clock);
    if (stall || dp_step || wb_valid) pulses++;
    check("non-multdiv no stall", pulses, 32'(0));
    next_cycle;

    // Flush in the accept cycle blocks acceptance
    start_op(1'b0, 5'd6, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    check("flush@accept stall/load", 32'({stall, dp_load, dp_is_div}), 32'(0));
    next_cycle;
    idle_inputs;
    @(negedge clock);
    check("flush@accept stays idle", 32'({stall, dp_step}), 32'(0));
    next_cycle;

    // Flush at cycle 10 of RUN
    start_op(1'b0, 5'd6, 1'b0);
    next_cycle;
    idle_inputs;
    repeat (9) next_cycle;
    flush = 1'b1;
    @(negedge clock);
    check("flush@run stall/step", 32'({stall, dp_step}), 32'(3));
    next_cycle;
    flush = 1'b0;
    @(negedge clock);
    check("flush@run next idle", 32'({stall, dp_step}), 32'(0));
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle;
      @(negedge clock);
      if (wb_valid || stall) pulses++;
    end
    check("flush@run no later wb", pulses, 32'(0));
    next_cycle;

    // Flush in DONE suppresses the write-back
    start_op(1'b0, 5'd8, 1'b0);
    next_cycle;
    idle_inputs;
    repeat (32) next_cycle;
    flush = 1'b1;
    @(negedge clock);
    check("flush@done wb_valid", 32'(wb_valid), 32'(0));
    next_cycle;
    flush = 1'b0;
    @(negedge clock);
    check("flush@done next idle", 32'({stall, wb_valid}), 32'(0));
    next_cycle;

    // Reset mid-RUN
    start_op(1'b1, 5'd9, 1'b0);
    next_cycle;
    idle_inputs;
    repeat (4) next_cycle;
    reset = 1'b0;
    @(negedge clock);
    check("reset@run outputs zero", all_outs(), 32'(0));
    next_cycle;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clock);
      if (wb_valid || stall || dp_step) pulses++;
      next_cycle;
    end
    check("reset@run no wb", pulses, 32'(0));

    // Back-to-back: div rd=3, mul rd=4 presented from the div's DONE cycle
    start_op(1'b1, 5'd3, 1'b0);
    next_cycle;
    idle_inputs;
    repeat (32) next_cycle;
    start_op(1'b0, 5'd4, 1'b0);
    @(negedge clock);
    check("b2b div done wb_rd", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd3}));
    check("b2b div done is_div", 32'(dp_is_div), 32'(1));
    check("b2b no accept in done", 32'({stall, dp_load}), 32'(0));
    next_cycle;
    @(negedge clock);
    check("b2b mul accept", 32'({stall, dp_load, dp_is_div}), 32'(6));
    next_cycle;
    idle_inputs;
    repeat (32) next_cycle;
    @(negedge clock);
    check("b2b mul done wb_rd", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd4}));
    check("b2b mul done is_div", 32'(dp_is_div), 32'(0));
    next_cycle;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
